axi_m0_read_path: RTL and testbench
===================================

Name: axi_m0_read_path

Overview:
- Master-0 read-request path of the AXI interconnect.
- Accepts up to two read commands per cycle into a command FIFO and pops them one at a time.
- Expands each command into per-beat byte addresses that drive an external synchronous memory (read-enable plus address), and returns each beat's data with its tag and a last flag.

Parameters:
M, 2, number of masters; interface compatibility only, must be >=1.
S, 2, number of slaves; interface compatibility only, must be >=1.
NUM_OUTSTANDING_TRANS, 2, command FIFO depth is 2*NUM_OUTSTANDING_TRANS entries.
BUS_WIDTH, 32, data width in bits; maximum beat size is 4 bytes.
ID_WIDTH, 1, tag width.
ADDR_WIDTH, 32, address width.

Ports:
clk in 1 single clock, rising edge
clr in 1 asynchronous active-high reset
M0R_fifo_write0 / M0R_fifo_write1 in 1 enqueue strobes for command ports 0/1
M0R_tag_in0/1 in ID_WIDTH transaction tag
M0R_address_in0/1 in ADDR_WIDTH start byte address
M0R_len_in0/1 in 4 beats minus 1
M0R_size_in0/1 in 2 bytes per beat: 0=1, 1=2, 2=4; 3 is treated as 4
M0R_burst_in0/1 in 2 burst type: 0=FIXED, 1=INCR, 2=WRAP, 3 is treated as INCR
M0R_lock_in0/1 in 2 stored, unused
M0R_cache_in0/1 in 4 stored, unused
M0R_prot_in0/1 in 3 stored, unused
M0R_address_out out ADDR_WIDTH beat byte address to memory
M0R_memread out 1 memory read enable
M0R_data_in in BUS_WIDTH memory read data, valid one cycle after M0R_memread
M0R_rdata out BUS_WIDTH returned beat data
M0R_rvalid out 1 beat valid
M0R_rlast out 1 final beat of burst
M0R_rid out ID_WIDTH tag of returned beat
M0R_fifo_full out 1 FIFO cannot accept a command

Behaviour:
- Reset (clr=1, asynchronous): FIFO emptied, FSM to IDLE, all outputs 0; strobes ignored while clr=1. Reset mid-burst aborts the burst; no further rvalid.
- Enqueue on a rising edge when a strobe is high. Both high: port 0 entry is written ahead of port 1. Exactly one free slot: port 0 accepted, port 1 dropped. Full: all writes dropped.
- Simultaneous pop and push is allowed.
- M0R_fifo_full = free slots == 0.
- FSM state IDLE: if the FIFO is non-empty, pop the head into working registers (addr, beats remaining = len, size, burst, tag), go to BURST. M0R_memread=0.
- FSM state BURST: M0R_memread=1, M0R_address_out = current address.
  - Each cycle, advance the address and decrement the count.
  - After the beat with count 0, return to IDLE. There is exactly one bubble cycle between bursts.
- Address advance, with bytes = 1<<size:
  - FIXED: unchanged.
  - INCR: next = (addr & ~(bytes-1)) + bytes. The first beat may be unaligned; later beats are aligned.
  - WRAP: boundary = (len+1)*bytes; the aligned address wraps within the boundary-aligned window.
- Return path: M0R_rvalid, M0R_rlast and M0R_rid are registered copies of memread, last-beat flag and tag, delayed one cycle. M0R_rdata = M0R_data_in, combinational pass-through.
- There is no backpressure: one beat per cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro M0R_RDATA_LANE_ALIGN_EN.
- Defined: M0R_rdata = M0R_data_in shifted right by 8*(beat address[1:0]), then masked to bytes*8 bits (narrow data lands in the low bits). This needs a registered copy of the beat's addr[1:0] and size.
- Undefined: raw pass-through.

Decomposition:
- Package axi_pkg: burst encodings (FIXED/INCR/WRAP), size encodings, command entry struct (tag, addr, len, size, burst, lock, cache, prot), FSM state enum.
- Sub-module m0r_cmd_fifo: dual-write, single-read, circular, with a count register.

Test Plan:
1. Reset, then in one cycle write port0 {tag0, 0x00, len3, size1, INCR} and port1 {tag1, 0x08, len2, size2, INCR} -> addresses 0x00, 0x02, 0x04, 0x06 with rid=0, rlast on the 4th beat; one bubble; then 0x08, 0x0C, 0x10 with rid=1.
2. Write port0 {0x14, len2, size0, INCR} and port1 {0x1E, len1, size2, INCR} -> 0x14, 0x15, 0x16 then 0x1E, 0x20; rvalid one cycle after each memread.
3. WRAP: addr 0x0C, len3, size2 -> 0x0C, 0x00, 0x04, 0x08. FIXED: addr 0x10, len2 -> 0x10 three times.
4. Fill: 3 single writes then a dual write with the FIFO stalled in burst -> port0 accepted, port1 dropped, fifo_full=1, 4 bursts total.
5. Assert clr in the middle of beat 2 of a 4-beat burst -> memread, rvalid and fifo_full go to 0 immediately; no activity after release until new writes.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: burst/size encodings, command control fields and read-path FSM states
package axi_pkg;
  typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2, BURST_RSVD = 2'd3} burst_e;
  typedef enum logic [1:0] {SIZE_1B = 2'd0, SIZE_2B = 2'd1, SIZE_4B = 2'd2, SIZE_RSVD = 2'd3} size_e;
  typedef struct packed {
    logic [3:0] len;
    size_e      size;
    burst_e     burst;
    logic [1:0] lock;
    logic [3:0] cache;
    logic [2:0] prot;
  } cmd_ctl_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;
  function automatic size_e eff_size(input logic [1:0] s);
    return (s == 2'd3) ? SIZE_4B : size_e'(s);
  endfunction
  function automatic burst_e eff_burst(input logic [1:0] b);
    return (b == 2'd3) ? BURST_INCR : burst_e'(b);
  endfunction
endpackage

// File: rtl/m0r_cmd_fifo.sv
// m0r_cmd_fifo: dual-write, single-read circular command FIFO with an occupancy count
module m0r_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         i_wr0,
  input  logic [W-1:0] i_wd0,
  input  logic         i_wr1,
  input  logic [W-1:0] i_wd1,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_acc0, w_acc1, w_pop;
  logic [PW-1:0] w_wptr1;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  // port 0 claims the first free slot; port 1 only fits if another slot remains
  always_comb begin
    w_acc0  = i_wr0 && (r_count != FULL_CNT);
    w_acc1  = i_wr1 && ((r_count + CW'(w_acc0)) != FULL_CNT);
    w_pop   = i_rd && (r_count != '0);
    w_wptr1 = w_acc0 ? inc(r_wptr) : r_wptr;
  end
  // entry storage; validity is tracked entirely by the pointers and count
  always_ff @(posedge clk) begin
    if (w_acc0) r_mem[r_wptr] <= i_wd0;
    if (w_acc1) r_mem[w_wptr1] <= i_wd1;
  end
  // pointers and occupancy; push and pop may share an edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_acc1 ? inc(w_wptr1) : w_wptr1;
      r_rptr  <= w_pop ? inc(r_rptr) : r_rptr;
      r_count <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop);
    end
  end
  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
endmodule

// File: rtl/axi_m0_read_path.sv
// axi_m0_read_path: master-0 read path; queues commands, expands bursts into memory beats, returns tagged data
// Optional: define M0R_RDATA_LANE_ALIGN_EN to right-align and mask narrow beats on M0R_rdata.
module axi_m0_read_path
  import axi_pkg::*;
#(
  parameter int M = 2,
  parameter int S = 2,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  parameter int BUS_WIDTH = 32,
  parameter int ID_WIDTH = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  M0R_fifo_write0,
  input  logic                  M0R_fifo_write1,
  input  logic [ID_WIDTH-1:0]   M0R_tag_in0,
  input  logic [ID_WIDTH-1:0]   M0R_tag_in1,
  input  logic [ADDR_WIDTH-1:0] M0R_address_in0,
  input  logic [ADDR_WIDTH-1:0] M0R_address_in1,
  input  logic [3:0]            M0R_len_in0,
  input  logic [3:0]            M0R_len_in1,
  input  logic [1:0]            M0R_size_in0,
  input  logic [1:0]            M0R_size_in1,
  input  logic [1:0]            M0R_burst_in0,
  input  logic [1:0]            M0R_burst_in1,
  input  logic [1:0]            M0R_lock_in0,
  input  logic [1:0]            M0R_lock_in1,
  input  logic [3:0]            M0R_cache_in0,
  input  logic [3:0]            M0R_cache_in1,
  input  logic [2:0]            M0R_prot_in0,
  input  logic [2:0]            M0R_prot_in1,
  output logic [ADDR_WIDTH-1:0] M0R_address_out,
  output logic                  M0R_memread,
  input  logic [BUS_WIDTH-1:0]  M0R_data_in,
  output logic [BUS_WIDTH-1:0]  M0R_rdata,
  output logic                  M0R_rvalid,
  output logic                  M0R_rlast,
  output logic [ID_WIDTH-1:0]   M0R_rid,
  output logic                  M0R_fifo_full
);
  localparam int DEPTH = 2 * NUM_OUTSTANDING_TRANS;
  localparam int unused_ms = M + S;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  typedef struct packed {
    logic [ID_WIDTH-1:0]   tag;
    logic [ADDR_WIDTH-1:0] addr;
    cmd_ctl_t              ctl;
  } cmd_t;
  cmd_t                  w_wd0, w_wd1, w_head;
  logic                  w_empty, w_full, w_pop, w_memread, w_last;
  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_bytes, w_incr, w_bnd, w_wrap, w_addr_nxt;
  logic [3:0]            r_cnt, r_len;
  size_e                 r_size;
  burst_e                r_burst;
  logic [ID_WIDTH-1:0]   r_tag, r_rid;
  logic                  r_rvalid, r_rlast;
  logic                  w_unused_attr;
  assign w_wd0 = '{tag: M0R_tag_in0, addr: M0R_address_in0,
                   ctl: '{len: M0R_len_in0, size: size_e'(M0R_size_in0), burst: burst_e'(M0R_burst_in0),
                          lock: M0R_lock_in0, cache: M0R_cache_in0, prot: M0R_prot_in0}};
  assign w_wd1 = '{tag: M0R_tag_in1, addr: M0R_address_in1,
                   ctl: '{len: M0R_len_in1, size: size_e'(M0R_size_in1), burst: burst_e'(M0R_burst_in1),
                          lock: M0R_lock_in1, cache: M0R_cache_in1, prot: M0R_prot_in1}};
  assign w_unused_attr = ^{w_head.ctl.lock, w_head.ctl.cache, w_head.ctl.prot};
  m0r_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk(clk), .clr(clr),
    .i_wr0(M0R_fifo_write0), .i_wd0(w_wd0),
    .i_wr1(M0R_fifo_write1), .i_wd1(w_wd1),
    .i_rd(w_pop), .o_rdata(w_head),
    .o_empty(w_empty), .o_full(w_full)
  );
  // next beat address: FIXED holds, INCR steps from the aligned address, WRAP folds the step into the burst window
  always_comb begin
    w_bytes    = A_ONE << r_size;
    w_incr     = (r_addr & ~(w_bytes - A_ONE)) + w_bytes;
    w_bnd      = (ADDR_WIDTH'(r_len) + A_ONE) * w_bytes;
    w_wrap     = (r_addr & ~(w_bnd - A_ONE)) | (w_incr & (w_bnd - A_ONE));
    w_addr_nxt = (r_burst == BURST_FIXED) ? r_addr : (r_burst == BURST_WRAP) ? w_wrap : w_incr;
  end
  // IDLE pops a waiting command; BURST issues one beat per cycle until the count-0 beat
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_memread   = 1'b0;
    w_last      = 1'b0;
    if (r_state == ST_IDLE) begin
      w_pop       = !w_empty;
      w_state_nxt = w_empty ? ST_IDLE : ST_BURST;
    end else begin
      w_memread   = 1'b1;
      w_last      = (r_cnt == 4'd0);
      w_state_nxt = w_last ? ST_IDLE : ST_BURST;
    end
  end
  // state, working registers and the one-cycle-delayed return flags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_size   <= SIZE_1B;
      r_burst  <= BURST_FIXED;
      r_tag    <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_addr  <= w_head.addr;
        r_cnt   <= w_head.ctl.len;
        r_len   <= w_head.ctl.len;
        r_size  <= eff_size(w_head.ctl.size);
        r_burst <= eff_burst(w_head.ctl.burst);
        r_tag   <= w_head.tag;
      end else if (r_state == ST_BURST) begin
        r_addr <= w_addr_nxt;
        r_cnt  <= r_cnt - 4'd1;
      end
      r_rvalid <= w_memread;
      r_rlast  <= w_last;
      r_rid    <= w_memread ? r_tag : '0;
    end
  end
`ifdef M0R_RDATA_LANE_ALIGN_EN
  localparam logic [BUS_WIDTH-1:0] MASK8  = BUS_WIDTH'(8'hFF);
  localparam logic [BUS_WIDTH-1:0] MASK16 = BUS_WIDTH'(16'hFFFF);
  logic [1:0]           r_lane;
  size_e                r_lane_size;
  logic [BUS_WIDTH-1:0] w_shifted;
  // remember where the beat sits so its data can be aligned when it returns
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_lane      <= '0;
      r_lane_size <= SIZE_1B;
    end else if (w_memread) begin
      r_lane      <= r_addr[1:0];
      r_lane_size <= r_size;
    end
  end
  // shift the addressed byte lane down and mask to the beat width
  always_comb begin
    w_shifted = M0R_data_in >> {r_lane, 3'b000};
    M0R_rdata = (r_lane_size == SIZE_1B) ? (w_shifted & MASK8) :
                (r_lane_size == SIZE_2B) ? (w_shifted & MASK16) : w_shifted;
  end
`else
  assign M0R_rdata = M0R_data_in;
`endif
  assign M0R_address_out = r_addr;
  assign M0R_memread     = w_memread;
  assign M0R_rvalid      = r_rvalid;
  assign M0R_rlast       = r_rlast;
  assign M0R_rid         = r_rid;
  assign M0R_fifo_full   = w_full;
endmodule

// File: tb/tb_axi_m0_read_path.sv
// tb_axi_m0_read_path: randomized scoreboard bench for the master-0 read path
module tb_axi_m0_read_path;
  localparam int DEPTH = 4;
`ifdef M0R_RDATA_LANE_ALIGN_EN
  localparam bit LANE = 1'b1;
`else
  localparam bit LANE = 1'b0;
`endif
  typedef struct packed {
    logic        tag;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  size;
    logic [1:0]  burst;
  } cmd_s;
  typedef struct {
    logic [31:0] addr;
    logic        tag;
    logic        last;
    int          sz;
    int          cyc;
  } beat_s;
  typedef struct {
    int          cyc;
    logic        tag;
    logic        last;
    logic [31:0] data;
  } ret_s;
  logic        clk = 1'b0, clr = 1'b1;
  logic        wr0 = 1'b0, wr1 = 1'b0;
  cmd_s        c0 = '0, c1 = '0;
  logic [1:0]  lk0 = '0, lk1 = '0;
  logic [3:0]  ca0 = '0, ca1 = '0;
  logic [2:0]  pr0 = '0, pr1 = '0;
  logic [31:0] data_in = '0;
  logic [31:0] addr_out, rdata;
  logic        memread, rvalid, rlast, rid, full;
  cmd_s        mq[$];
  beat_s       exp_q[$];
  ret_s        ret_q[$];
  int          cyc = 0, gap = 0;
  int          n_cmp = 0, n_bad = 0;

  axi_m0_read_path dut (
    .clk(clk), .clr(clr),
    .M0R_fifo_write0(wr0), .M0R_fifo_write1(wr1),
    .M0R_tag_in0(c0.tag), .M0R_tag_in1(c1.tag),
    .M0R_address_in0(c0.addr), .M0R_address_in1(c1.addr),
    .M0R_len_in0(c0.len), .M0R_len_in1(c1.len),
    .M0R_size_in0(c0.size), .M0R_size_in1(c1.size),
    .M0R_burst_in0(c0.burst), .M0R_burst_in1(c1.burst),
    .M0R_lock_in0(lk0), .M0R_lock_in1(lk1),
    .M0R_cache_in0(ca0), .M0R_cache_in1(ca1),
    .M0R_prot_in0(pr0), .M0R_prot_in1(pr1),
    .M0R_address_out(addr_out), .M0R_memread(memread),
    .M0R_data_in(data_in), .M0R_rdata(rdata),
    .M0R_rvalid(rvalid), .M0R_rlast(rlast), .M0R_rid(rid),
    .M0R_fifo_full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] raw, input logic [31:0] a, input int sz);
    logic [31:0] s;
    s = LANE ? (raw >> {a[1:0], 3'b000}) : raw;
    return (LANE && sz == 0) ? (s & 32'hFF) : (LANE && sz == 1) ? (s & 32'hFFFF) : s;
  endfunction

  // burst expansion straight from the addressing rules, using modular arithmetic
  function automatic void gen_beats(input cmd_s c);
    logic [31:0] a, bytes, bnd, step;
    int sz, bt;
    sz    = (c.size == 2'd3) ? 2 : int'(c.size);
    bt    = (c.burst == 2'd3) ? 1 : int'(c.burst);
    bytes = 32'd1 << sz;
    bnd   = (32'(c.len) + 32'd1) * bytes;
    a     = c.addr;
    for (int i = 0; i <= int'(c.len); i++) begin
      exp_q.push_back('{addr: a, tag: c.tag, last: (i == int'(c.len)), sz: sz, cyc: cyc + i});
      step = a - (a % bytes) + bytes;
      if (bt == 1) a = step;
      else if (bt == 2) a = a - (a % bnd) + (step % bnd);
    end
  endfunction

  // reference model: a DEPTH-entry queue; a command starts when idle and occupies len+2 cycles
  always @(posedge clk) begin
    int occ;
    bit a0, a1;
    cmd_s c;
    cyc++;
    if (clr) begin
      mq.delete();
      gap = 0;
    end else begin
      occ = mq.size();
      a0  = wr0 && occ < DEPTH;
      a1  = wr1 && (occ + int'(a0)) < DEPTH;
      if (gap > 0) gap--;
      else if (occ > 0) begin
        c = mq.pop_front();
        gen_beats(c);
        gap = int'(c.len) + 1;
      end
      if (a0) mq.push_back(c0);
      if (a1) mq.push_back(c1);
    end
  end

  // monitor: checks returns first, then beats, then drives the memory response
  always @(negedge clk) begin
    beat_s e;
    ret_s r;
    if (clr) begin
      exp_q.delete();
      ret_q.delete();
      chk("reset memread", memread, 0);
      chk("reset rvalid", rvalid, 0);
      chk("reset rlast", rlast, 0);
      chk("reset fifo_full", full, 0);
      chk("reset address_out", addr_out, 0);
    end else begin
      if (rvalid) begin
        if (ret_q.size() == 0) chk("rvalid with nothing pending", rvalid, 0);
        else begin
          r = ret_q.pop_front();
          chk("rvalid cycle", cyc, r.cyc);
          chk("rid", rid, r.tag);
          chk("rlast", rlast, r.last);
          chk("rdata", rdata, r.data);
        end
      end else if (ret_q.size() > 0 && ret_q[0].cyc <= cyc) begin
        chk("rvalid missing", rvalid, 1);
        void'(ret_q.pop_front());
      end
      if (memread) begin
        if (exp_q.size() == 0) chk("memread with nothing pending", memread, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat address", addr_out, e.addr);
          chk("beat cycle", cyc, e.cyc);
          ret_q.push_back('{cyc: cyc + 1, tag: e.tag, last: e.last, data: exp_data(memf(e.addr), e.addr, e.sz)});
        end
        data_in = memf(addr_out);
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("memread missing", memread, 1);
        void'(exp_q.pop_front());
      end
      chk("fifo_full", full, mq.size() == DEPTH);
    end
  end

  function automatic cmd_s mk(input logic t, input logic [31:0] a, input int l, input int s, input int b);
    return '{tag: t, addr: a, len: 4'(l), size: 2'(s), burst: 2'(b)};
  endfunction

  function automatic cmd_s rnd();
    int b, l;
    b = $urandom_range(0, 3);
    l = (b == 2) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 7);
    return mk(1'($urandom), $urandom, l, $urandom_range(0, 3), b);
  endfunction

  task automatic drive(input bit e0, input cmd_s a, input bit e1, input cmd_s b);
    @(negedge clk);
    wr0 = e0; wr1 = e1; c0 = a; c1 = b;
    lk0 = 2'($urandom); lk1 = 2'($urandom);
    ca0 = 4'($urandom); ca1 = 4'($urandom);
    pr0 = 3'($urandom); pr1 = 3'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr0 = 1'b0; wr1 = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    idle(1);
    while ((exp_q.size() + ret_q.size() + mq.size()) != 0 && n < 400) begin
      idle(1);
      n++;
    end
    chk("drain outstanding", exp_q.size() + ret_q.size() + mq.size(), 0);
  endtask

  initial begin
    cmd_s z;
    z = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    idle(2);
    // two INCR bursts written together: halfword then word beats
    drive(1, mk(0, 32'h00, 3, 1, 1), 1, mk(1, 32'h08, 2, 2, 1));
    drain();
    // byte INCR, then an unaligned word INCR start
    drive(1, mk(0, 32'h14, 2, 0, 1), 1, mk(1, 32'h1E, 1, 2, 1));
    drain();
    // WRAP window and FIXED repetition
    drive(1, mk(1, 32'h0C, 3, 2, 2), 1, mk(0, 32'h10, 2, 2, 0));
    drain();
    // address rollover and reserved size/burst encodings
    drive(1, mk(0, 32'hFFFF_FFFE, 2, 1, 1), 1, mk(1, 32'hFFFF_FFF9, 2, 3, 3));
    drain();
    // fill while stalled in a long burst; dual writes at one and zero free slots
    drive(1, mk(0, 32'h100, 15, 0, 1), 0, z);
    drive(1, mk(1, 32'h200, 1, 2, 1), 0, z);
    drive(1, mk(0, 32'h300, 1, 2, 1), 0, z);
    drive(1, mk(1, 32'h400, 1, 2, 1), 0, z);
    drive(1, mk(0, 32'h500, 1, 2, 1), 1, mk(1, 32'h600, 1, 2, 1));
    drive(1, mk(1, 32'h700, 1, 2, 1), 1, mk(0, 32'h800, 1, 2, 1));
    drain();
    // asynchronous reset during beat 2 of a 4-beat burst with a full FIFO
    drive(1, mk(1, 32'h40, 3, 2, 1), 1, mk(0, 32'h80, 7, 2, 1));
    drive(1, mk(0, 32'hC0, 1, 2, 1), 1, mk(1, 32'hD0, 1, 2, 1));
    drive(1, mk(1, 32'hE0, 1, 2, 1), 0, z);
    @(posedge clk);
    #2;
    clr = 1'b1;
    wr0 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    clr = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("post-reset memread", memread, 0);
      chk("post-reset rvalid", rvalid, 0);
    end
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 3, rnd(), $urandom_range(0, 9) < 3, rnd());
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
